// File: rtl/key_note_decoder_if.sv
// key_note_decoder_if: PS/2 byte input and decoded note output bundle.
// Signals: ps2_data/ps2_valid carry scan-code bytes into the decoder.
// note_in/note/octave/key_held carry the decoded note back out.
interface key_note_decoder_if;
  logic [7:0] ps2_data;
  logic       ps2_valid;
  logic       note_in;
  logic [3:0] note;
  logic [2:0] octave;
  logic       key_held;
  modport master (output ps2_data, ps2_valid, input note_in, note, octave, key_held);
  modport slave (input ps2_data, ps2_valid, output note_in, note, octave, key_held);
endinterface

// File: rtl/key_note_decoder.sv
// key_note_decoder: PS/2 set-2 scan codes to note/octave events (macro OCTAVE_KEYS_EN adds Z/X octave keys).
// Ports: clk, reset (sync active-low), bus (slave: ps2_data/ps2_valid in; note_in/note/octave/key_held out).
module key_note_decoder (
  input logic clk,
  input logic reset,
  key_note_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  state_t state;
  logic [7:0] held_code;
  logic [3:0] map_note;
  logic mapped;
  always_comb begin
    mapped = 1'b1;
    map_note = 4'd0;
    case (bus.ps2_data)
      8'h1C: map_note = 4'd0;
      8'h1D: map_note = 4'd1;
      8'h1B: map_note = 4'd2;
      8'h24: map_note = 4'd3;
      8'h23: map_note = 4'd4;
      8'h2B: map_note = 4'd5;
      8'h2C: map_note = 4'd6;
      8'h34: map_note = 4'd7;
      8'h35: map_note = 4'd8;
      8'h33: map_note = 4'd9;
      8'h3C: map_note = 4'd10;
      8'h3B: map_note = 4'd11;
      default: mapped = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      bus.note_in <= 1'b0;
      bus.note <= 4'd0;
      bus.octave <= 3'd4;
      bus.key_held <= 1'b0;
      held_code <= 8'h00;
    end else begin
      bus.note_in <= 1'b0;
      if (bus.ps2_valid) begin
        case (state)
          IDLE: begin
            if (bus.ps2_data == 8'hF0) state <= BRK;
            else if (bus.ps2_data == 8'hE0) state <= EXT;
            // a repeat of the held key is typematic and must stay silent
            else if (mapped && (!bus.key_held || bus.ps2_data != held_code)) begin
              bus.note <= map_note;
              bus.note_in <= 1'b1;
              bus.key_held <= 1'b1;
              held_code <= bus.ps2_data;
            end
`ifdef OCTAVE_KEYS_EN
            else if (bus.ps2_data == 8'h1A) bus.octave <= (bus.octave == 3'd0) ? 3'd0 : bus.octave - 3'd1;
            else if (bus.ps2_data == 8'h22) bus.octave <= (bus.octave == 3'd6) ? 3'd6 : bus.octave + 3'd1;
`endif
          end
          BRK: begin
            state <= IDLE;
            // releasing a key other than the last-triggering one leaves key_held alone
            if (bus.key_held && bus.ps2_data == held_code) bus.key_held <= 1'b0;
          end
          EXT: state <= (bus.ps2_data == 8'hF0) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/key_note_decoder.md
KEY_NOTE_DECODER -- requirements
Module: key_note_decoder

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: ps2_data  input  8  received PS/2 scan-code byte (set 2); valid only when ps2_valid=1.
REQ-004 SHALL have port: ps2_valid  input  1  one-cycle strobe; a new byte is present on ps2_data.
REQ-005 SHALL have port: note_in  output  1  one-cycle pulse; a new note is on note/octave.
REQ-006 SHALL have port: note  output  4  note index: 0=C, 1=C#, ... 11=B; 12-15 never driven.
REQ-007 SHALL have port: octave  output  3  octave 0-6; 4 = middle C octave.
REQ-008 SHALL have port: key_held  output  1  high while the last-triggering note key is physically down.

Function
REQ-009 SHALL map make codes to notes: 1C->0, 1D->1, 1B->2, 24->3, 23->4, 2B->5, 2C->6, 34->7, 35->8, 33->9, 3C->10, 3B->11; all other codes are "unmapped".
REQ-010 SHALL run a 4-state byte FSM: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0); state advances only on ps2_valid.
REQ-011 IDLE: F0->BRK; E0->EXT; mapped make->note action (REQ-012); other bytes ignored, stay IDLE.
REQ-012 Note action: if key_held=0 or code differs from held code, SHALL latch note, assert note_in for exactly the cycle after the ps2_valid cycle, set key_held=1, store held code.
REQ-013 Typematic repeat (make of the held code while key_held=1) SHALL produce no note_in pulse and no output change.
REQ-014 BRK: any byte returns to IDLE; if byte equals held code and key_held=1, key_held SHALL clear next cycle; else no effect.
REQ-015 EXT: F0->EXT_BRK; any other byte->IDLE with no effect. EXT_BRK: any byte->IDLE with no effect (extended keys fully ignored).
REQ-016 note and octave SHALL be registered, change only in the cycle note_in asserts (or per REQ-020), and hold otherwise.
REQ-017 note_in SHALL never be high for two consecutive cycles; max one pulse per ps2_valid.
REQ-018 ps2_valid low SHALL leave all state and outputs unchanged; ps2_data ignored.

Reset
REQ-019 reset=0 at a rising edge SHALL force: FSM IDLE, note_in=0, note=0, octave=4, key_held=0, held code=00; reset dominates a coincident ps2_valid, including mid-sequence (after F0/E0).

Configuration
REQ-020 Macro OCTAVE_KEYS_EN: when defined, make code 1A (Z) SHALL decrement and 22 (X) SHALL increment octave in IDLE, saturating at 0 and 6, no note_in pulse, held note unaffected; the next note action uses the new octave.
REQ-021 When OCTAVE_KEYS_EN is undefined, octave SHALL be constant 4 and 1A/22 are unmapped.

Verification
REQ-022 Reset, then ps2 bytes 1C -> note_in pulse 1 cycle later, note=0, octave=4, key_held=1.
REQ-023 1C, 1C, 1C (typematic) -> exactly one note_in pulse; then F0,1C -> key_held=0, no pulse.
REQ-024 1C then 23 (no break) -> two pulses, note=4 after second; F0,1C -> key_held stays 1; F0,23 -> key_held=0.
REQ-025 E0,1C then E0,F0,1C then 5A -> no note_in, outputs unchanged, FSM ends IDLE.
REQ-026 With OCTAVE_KEYS_EN: 22 x3 then 1B -> octave=6 (saturated), note=2, one pulse; 1A x8 -> octave=0; without macro same stimulus -> octave=4.
REQ-027 F0 then reset pulse then 1C -> note_in pulse, note=0 (break sequence aborted by reset).
